// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives X/Y through 00,01,10,11 for NUM_SWEEPS sweeps,
// samples the five basic-gate outputs after SETTLE cycles, and reports the
// error count, the first failing vector/mask and a pass flag.
module gate_sweep_checker #(
    parameter int unsigned SETTLE     = 1,
    parameter int unsigned NUM_SWEEPS = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             X,
    output logic             Y,
    input  logic             AND,
    input  logic             OR,
    input  logic             NOT,
    input  logic             NAND,
    input  logic             NOR,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_valid,
    output logic [1:0]       first_err_vec,
    output logic [4:0]       first_err_mask
);

    localparam int unsigned SET_W = (SETTLE > 1)     ? $clog2(SETTLE)     : 1;
    localparam int unsigned SWP_W = (NUM_SWEEPS > 1) ? $clog2(NUM_SWEEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [SWP_W-1:0] swp_q, swp_d;
    logic [SET_W-1:0] set_q, set_d;
    logic             x_q, x_d, y_q, y_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evld_q, evld_d;
    logic [1:0]       evec_q, evec_d;
    logic [4:0]       emask_q, emask_d;
    logic [4:0]       mask;

    // State and result registers; reset wipes any partial run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            swp_q   <= '0;
            set_q   <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            evld_q  <= 1'b0;
            evec_q  <= '0;
            emask_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            swp_q   <= swp_d;
            set_q   <= set_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            evld_q  <= evld_d;
            evec_q  <= evec_d;
            emask_q <= emask_d;
        end
    end

    // Next-state, sweep sequencing and result accumulation
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        swp_d   = swp_q;
        set_d   = set_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        evld_d  = evld_q;
        evec_d  = evec_q;
        emask_d = emask_q;

        // Expectations come from the registered X/Y actually being driven
        mask = {NOR  ^ ~(x_q | y_q),
                NAND ^ ~(x_q & y_q),
                NOT  ^ ~x_q,
                OR   ^ (x_q | y_q),
                AND  ^ (x_q & y_q)};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_APPLY;
                    vec_d   = '0;
                    swp_d   = '0;
                    set_d   = '0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    evld_d  = 1'b0;
                    evec_d  = '0;
                    emask_d = '0;
                end
            end
            S_APPLY: begin
                if (set_q == SET_W'(SETTLE - 1)) begin
                    set_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            S_SAMPLE: begin
                if (mask != '0) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (!evld_q) begin
                        evld_d  = 1'b1;
                        evec_d  = {x_q, y_q};
                        emask_d = mask;
                    end
                end
                if (vec_q == 2'd3 && swp_q == SWP_W'(NUM_SWEEPS - 1)) begin
                    // pass uses cnt_d so the final sample is included
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (cnt_d == '0);
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                end else begin
                    state_d = S_APPLY;
                    vec_d   = vec_q + 2'd1;
                    if (vec_q == 2'd3) begin
                        swp_d = swp_q + SWP_W'(1);
                    end
                    x_d = vec_d[1];
                    y_d = vec_d[0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign X              = x_q;
    assign Y              = y_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = cnt_q;
    assign err_valid      = evld_q;
    assign first_err_vec  = evec_q;
    assign first_err_mask = emask_q;

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Self-checking driver/receiver for the two-input basic-gate block. It drives the X/Y inputs through every combination (00, 01, 10, 11), waits a settle time, samples the five gate outputs and compares them against the expected truth table. It records the error count and the first failing vector, then reports pass/fail. It sits on the opposite side of the basic-gate interface, as on-chip BIST or as a synthesizable bench companion.

## Interface
Parameters:
- SETTLE, 1: cycles X/Y are held before sampling; legal range ≥1.
- NUM_SWEEPS, 1: number of full 4-vector sweeps per run; ≥1.
- CNT_W, 8: width of the error counter.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; accepted only in IDLE or DONE.
- X  out  1  gate input A; registered.
- Y  out  1  gate input B; registered.
- AND  in  1  DUT output; expected X&Y.
- OR  in  1  DUT output; expected X|Y.
- NOT  in  1  DUT output; expected ~X.
- NAND  in  1  DUT output; expected ~(X&Y).
- NOR  in  1  DUT output; expected ~(X|Y).
- busy  out  1  high in APPLY/SAMPLE.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  out  CNT_W  mismatching samples; saturates at all-ones.
- err_valid  out  1  a first error has been captured this run.
- first_err_vec  out  2  {X,Y} of the first mismatch.
- first_err_mask  out  5  mismatch bits of the first mismatch: [0]AND [1]OR [2]NOT [3]NAND [4]NOR.

## Operation
- States:
  - IDLE: X=Y=0; waits for start.
  - APPLY: holds the current vector for SETTLE cycles.
  - SAMPLE: compares the DUT outputs for one cycle.
  - DONE: holds results until start.
- The vector counter vec[1:0] drives {X,Y}, with X as the MSB. Order within a sweep: 00, 01, 10, 11. The sweep counter counts up to NUM_SWEEPS-1.
- start in IDLE or DONE:
  - clears err_cnt, err_valid, first_err_*, pass, done, vec and the sweep counter;
  - enters APPLY.
- start in APPLY/SAMPLE is ignored.
- APPLY: the settle counter runs 0..SETTLE-1. On the last count the FSM goes to SAMPLE.
- SAMPLE:
  - mask = {NOR^exp_nor, NAND^exp_nand, NOT^exp_not, OR^exp_or, AND^exp_and}, with expectations computed from the registered X/Y.
  - If mask≠0, err_cnt increments by 1 per sample, not per bit, and saturates.
  - If mask≠0 and err_valid=0, capture first_err_vec={X,Y} and first_err_mask=mask, then set err_valid.
  - Next step: if vec==3 and the sweep counter is NUM_SWEEPS-1, go to DONE. Otherwise vec+1 (3 wraps to 0, sweep counter +1) and go back to APPLY.
- DONE: done=1, pass=(err_cnt==0). X/Y return to 0. Results hold until the next start.
- Reset (rst_n low, any state, including mid-run) immediately forces:
  - state IDLE;
  - X=Y=0, busy=0, done=0, pass=0, err_cnt=0, err_valid=0, first_err_vec=0, first_err_mask=0.
  - No partial result survives reset.

## Timing
- All outputs are registered. X/Y change only on the edge that enters APPLY for a new vector.
- start sampled high at edge k gives: APPLY and busy=1 from edge k, X/Y = the first vector.
- Each vector takes SETTLE+1 cycles (SETTLE in APPLY, 1 in SAMPLE).
- done rises at edge k + 4·NUM_SWEEPS·(SETTLE+1). busy falls on the same edge.
- err_cnt and first_err_* update on the edge that leaves SAMPLE. They are visible the cycle after the sample.
- The DUT path is combinational from X/Y. Sampling happens ≥SETTLE cycles after X/Y change.
- A restart from DONE takes effect at the next edge. The clear and the APPLY entry occur on that edge.
- rst_n deassertion is synchronised externally. The FSM leaves IDLE only on start.

## Test plan
- Ideal DUT model, SETTLE=1, NUM_SWEEPS=1, start at edge 0:
  - X/Y step 00→01→10→11, two cycles each;
  - done=1 at edge 8, pass=1, err_cnt=0, err_valid=0.
- NOR stuck-at-0:
  - err_cnt=1, first_err_vec=00, first_err_mask=5'b10000, pass=0.
- AND stuck-at-1:
  - err_cnt=3, first_err_vec=00, first_err_mask=5'b00001.
  - The later mismatches at 01 and 10 do not overwrite the capture.
- CNT_W=2, NUM_SWEEPS=2, all outputs inverted:
  - 8 mismatching samples; err_cnt saturates at 3;
  - first_err_mask=5'b11111 at vec 00;
  - done at edge 16.
- start pulsed again mid-run, in APPLY of vec 10:
  - ignored; done still at the original edge and results unchanged.
  - start in DONE clears all results and restarts from 00.
- rst_n low during SAMPLE of vec 01 with one error already counted:
  - all outputs return to their reset values immediately (asynchronously);
  - after release, with no start, the block stays in IDLE with X=Y=0.
